// File: rtl/pipe_pkg.sv
// Shared pipeline constants: ALU op codes, forward-select encodings and the NOP word.
package pipe_pkg;

    localparam logic [2:0]  ALU_ADD    = 3'd0;
    localparam logic [2:0]  ALU_SUB    = 3'd1;
    localparam logic [2:0]  ALU_AND    = 3'd2;
    localparam logic [2:0]  ALU_OR     = 3'd3;

    localparam logic [1:0]  FWD_REG    = 2'd0;
    localparam logic [1:0]  FWD_M      = 2'd1;
    localparam logic [1:0]  FWD_W      = 2'd2;

    localparam logic [31:0] INSTR_NOP  = 32'h0000_0000;

endpackage

// File: rtl/ex_fwd_mux.sv
// EX-stage 3:1 forwarding mux: register value, EX/MEM result or WB data.
// Any select outside the defined encodings falls back to the register value.
module ex_fwd_mux
    import pipe_pkg::*;
#(
    parameter int unsigned DW = 32
) (
    input  logic [1:0]    i_sel,
    input  logic [DW-1:0] i_reg,
    input  logic [DW-1:0] i_fwd_m,
    input  logic [DW-1:0] i_fwd_w,
    output logic [DW-1:0] o_data
);

    // Select the operand source from the current forward select.
    always_comb begin
        o_data = i_reg;
        case (i_sel)
            FWD_M:   o_data = i_fwd_m;
            FWD_W:   o_data = i_fwd_w;
            default: o_data = i_reg;
        endcase
    end

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register of the 5-stage MIPS core.
// Latches decoded operands/control, applies EX forwarding and the operand-B select.
// Edge priority: reset (low) > flush > bubble > hold > load.
// Optional feature macro IDEX_PERF_CNT_EN adds saturating bubble/flush event counters.
module id_ex_reg
    import pipe_pkg::*;
#(
    parameter int unsigned DW = 32,
    parameter int unsigned RW = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          hold,
    input  logic          bubble,
    input  logic          flush,
    input  logic [DW-1:0] pc_d,
    input  logic [31:0]   instr_d,
    input  logic [DW-1:0] rs_data_d,
    input  logic [DW-1:0] rt_data_d,
    input  logic [DW-1:0] imm_d,
    input  logic [2:0]    alu_op_d,
    input  logic          alu_src_d,
    input  logic          reg_write_d,
    input  logic [RW-1:0] wa_d,
    input  logic          mem_write_d,
    input  logic          mem_to_reg_d,
    input  logic [1:0]    rs_fwd_sel,
    input  logic [1:0]    rt_fwd_sel,
    input  logic [DW-1:0] fwd_m,
    input  logic [DW-1:0] fwd_w,
    output logic          valid_e,
    output logic [DW-1:0] pc_e,
    output logic [31:0]   instr_e,
    output logic [DW-1:0] imm_e,
    output logic [2:0]    alu_op_e,
    output logic [DW-1:0] alu_a_e,
    output logic [DW-1:0] alu_b_e,
    output logic [DW-1:0] rt_fwd_e,
    output logic          reg_write_e,
    output logic [RW-1:0] wa_e,
    output logic          mem_write_e,
    output logic          mem_to_reg_e
`ifdef IDEX_PERF_CNT_EN
    ,
    output logic [DW-1:0] bubble_cnt,
    output logic [DW-1:0] flush_cnt
`endif
);

    logic          r_valid;
    logic [DW-1:0] r_pc;
    logic [31:0]   r_instr;
    logic [DW-1:0] r_rs;
    logic [DW-1:0] r_rt;
    logic [DW-1:0] r_imm;
    logic [2:0]    r_alu_op;
    logic          r_alu_src;
    logic          r_reg_write;
    logic [RW-1:0] r_wa;
    logic          r_mem_write;
    logic          r_mem_to_reg;

    logic [DW-1:0] w_rs_fwd;
    logic [DW-1:0] w_rt_fwd;

    // Pipeline register with reset/flush/bubble/hold priority.
    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            r_valid      <= 1'b0;
            r_pc         <= '0;
            r_instr      <= INSTR_NOP;
            r_rs         <= '0;
            r_rt         <= '0;
            r_imm        <= '0;
            r_alu_op     <= ALU_ADD;
            r_alu_src    <= 1'b0;
            r_reg_write  <= 1'b0;
            r_wa         <= '0;
            r_mem_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
        end else if (bubble) begin
            // Bubble keeps the PC of the stalled instruction for debug/exception use.
            r_valid      <= 1'b0;
            r_pc         <= pc_d;
            r_instr      <= INSTR_NOP;
            r_rs         <= '0;
            r_rt         <= '0;
            r_imm        <= '0;
            r_alu_op     <= ALU_ADD;
            r_alu_src    <= 1'b0;
            r_reg_write  <= 1'b0;
            r_wa         <= '0;
            r_mem_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
        end else if (!hold) begin
            r_valid      <= 1'b1;
            r_pc         <= pc_d;
            r_instr      <= instr_d;
            r_rs         <= rs_data_d;
            r_rt         <= rt_data_d;
            r_imm        <= imm_d;
            r_alu_op     <= alu_op_d;
            r_alu_src    <= alu_src_d;
            // Writes to $0 are suppressed here so downstream never sees them.
            r_reg_write  <= reg_write_d && (wa_d != '0);
            r_wa         <= wa_d;
            r_mem_write  <= mem_write_d;
            r_mem_to_reg <= mem_to_reg_d;
        end
    end

    ex_fwd_mux #(
        .DW      (DW)
    ) u_rs_fwd (
        .i_sel   (rs_fwd_sel),
        .i_reg   (r_rs),
        .i_fwd_m (fwd_m),
        .i_fwd_w (fwd_w),
        .o_data  (w_rs_fwd)
    );

    ex_fwd_mux #(
        .DW      (DW)
    ) u_rt_fwd (
        .i_sel   (rt_fwd_sel),
        .i_reg   (r_rt),
        .i_fwd_m (fwd_m),
        .i_fwd_w (fwd_w),
        .o_data  (w_rt_fwd)
    );

    // Output drive: operand B is selected after forwarding.
    always_comb begin
        valid_e      = r_valid;
        pc_e         = r_pc;
        instr_e      = r_instr;
        imm_e        = r_imm;
        alu_op_e     = r_alu_op;
        alu_a_e      = w_rs_fwd;
        alu_b_e      = r_alu_src ? r_imm : w_rt_fwd;
        rt_fwd_e     = w_rt_fwd;
        reg_write_e  = r_reg_write;
        wa_e         = r_wa;
        mem_write_e  = r_mem_write;
        mem_to_reg_e = r_mem_to_reg;
    end

`ifdef IDEX_PERF_CNT_EN
    logic [DW-1:0] r_bubble_cnt;
    logic [DW-1:0] r_flush_cnt;

    // Saturating event counters; a flush masks a simultaneous bubble.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_bubble_cnt <= '0;
            r_flush_cnt  <= '0;
        end else if (flush) begin
            if (r_flush_cnt != '1) r_flush_cnt <= r_flush_cnt + 1'b1;
        end else if (bubble) begin
            if (r_bubble_cnt != '1) r_bubble_cnt <= r_bubble_cnt + 1'b1;
        end
    end

    assign bubble_cnt = r_bubble_cnt;
    assign flush_cnt  = r_flush_cnt;
`endif

endmodule

// File: tb/tb_id_ex_reg.sv
// Directed testbench for id_ex_reg; expected values are hand-computed constants.
// Build with IDEX_PERF_CNT_EN to also check the event counters.
module tb_id_ex_reg;

    localparam int unsigned DW = 32;
    localparam int unsigned RW = 5;

    logic          clk;
    logic          reset;
    logic          hold;
    logic          bubble;
    logic          flush;
    logic [DW-1:0] pc_d;
    logic [31:0]   instr_d;
    logic [DW-1:0] rs_data_d;
    logic [DW-1:0] rt_data_d;
    logic [DW-1:0] imm_d;
    logic [2:0]    alu_op_d;
    logic          alu_src_d;
    logic          reg_write_d;
    logic [RW-1:0] wa_d;
    logic          mem_write_d;
    logic          mem_to_reg_d;
    logic [1:0]    rs_fwd_sel;
    logic [1:0]    rt_fwd_sel;
    logic [DW-1:0] fwd_m;
    logic [DW-1:0] fwd_w;
    logic          valid_e;
    logic [DW-1:0] pc_e;
    logic [31:0]   instr_e;
    logic [DW-1:0] imm_e;
    logic [2:0]    alu_op_e;
    logic [DW-1:0] alu_a_e;
    logic [DW-1:0] alu_b_e;
    logic [DW-1:0] rt_fwd_e;
    logic          reg_write_e;
    logic [RW-1:0] wa_e;
    logic          mem_write_e;
    logic          mem_to_reg_e;
`ifdef IDEX_PERF_CNT_EN
    logic [DW-1:0] bubble_cnt;
    logic [DW-1:0] flush_cnt;
`endif

    int errors = 0;
    int checks = 0;

    id_ex_reg #(
        .DW           (DW),
        .RW           (RW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .hold         (hold),
        .bubble       (bubble),
        .flush        (flush),
        .pc_d         (pc_d),
        .instr_d      (instr_d),
        .rs_data_d    (rs_data_d),
        .rt_data_d    (rt_data_d),
        .imm_d        (imm_d),
        .alu_op_d     (alu_op_d),
        .alu_src_d    (alu_src_d),
        .reg_write_d  (reg_write_d),
        .wa_d         (wa_d),
        .mem_write_d  (mem_write_d),
        .mem_to_reg_d (mem_to_reg_d),
        .rs_fwd_sel   (rs_fwd_sel),
        .rt_fwd_sel   (rt_fwd_sel),
        .fwd_m        (fwd_m),
        .fwd_w        (fwd_w),
        .valid_e      (valid_e),
        .pc_e         (pc_e),
        .instr_e      (instr_e),
        .imm_e        (imm_e),
        .alu_op_e     (alu_op_e),
        .alu_a_e      (alu_a_e),
        .alu_b_e      (alu_b_e),
        .rt_fwd_e     (rt_fwd_e),
        .reg_write_e  (reg_write_e),
        .wa_e         (wa_e),
        .mem_write_e  (mem_write_e),
        .mem_to_reg_e (mem_to_reg_e)
`ifdef IDEX_PERF_CNT_EN
        ,
        .bubble_cnt   (bubble_cnt),
        .flush_cnt    (flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a full ID-stage instruction on the inputs.
    task automatic drive_id(input logic [31:0] pc, input logic [31:0] ins, input logic [31:0] rs,
                            input logic [31:0] rt, input logic [31:0] imm, input logic [2:0] op,
                            input logic src, input logic rw, input logic [4:0] wa,
                            input logic mw, input logic m2r);
        pc_d         = pc;
        instr_d      = ins;
        rs_data_d    = rs;
        rt_data_d    = rt;
        imm_d        = imm;
        alu_op_d     = op;
        alu_src_d    = src;
        reg_write_d  = rw;
        wa_d         = wa;
        mem_write_d  = mw;
        mem_to_reg_d = m2r;
    endtask

    // Every output must be zero (reset/flush state with selects at FWD_REG).
    task automatic check_all_zero(input string tag);
        check({tag, ".valid"}, {31'd0, valid_e}, 32'd0);
        check({tag, ".pc"}, pc_e, 32'd0);
        check({tag, ".instr"}, instr_e, 32'd0);
        check({tag, ".imm"}, imm_e, 32'd0);
        check({tag, ".alu_op"}, {29'd0, alu_op_e}, 32'd0);
        check({tag, ".alu_a"}, alu_a_e, 32'd0);
        check({tag, ".alu_b"}, alu_b_e, 32'd0);
        check({tag, ".rt_fwd"}, rt_fwd_e, 32'd0);
        check({tag, ".ctl"}, {25'd0, reg_write_e, wa_e, mem_write_e, mem_to_reg_e}, 32'd0);
    endtask

    initial begin
        reset = 1'b0; hold = 1'b0; bubble = 1'b0; flush = 1'b0;
        rs_fwd_sel = 2'd0; rt_fwd_sel = 2'd0; fwd_m = '0; fwd_w = '0;
        drive_id(32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);

        // Reset state.
        tick();
        tick();
        check_all_zero("reset");
`ifdef IDEX_PERF_CNT_EN
        check("reset.bubble_cnt", bubble_cnt, 32'd0);
        check("reset.flush_cnt", flush_cnt, 32'd0);
`endif

        // Normal load with register operand B.
        reset = 1'b1;
        drive_id(32'h3000, 32'h0123_4567, 32'd5, 32'd7, 32'h10, 3'd1, 1'b0, 1'b1, 5'd3,
                 1'b0, 1'b0);
        tick();
        check("load.valid", {31'd0, valid_e}, 32'd1);
        check("load.pc", pc_e, 32'h3000);
        check("load.instr", instr_e, 32'h0123_4567);
        check("load.alu_a", alu_a_e, 32'd5);
        check("load.alu_b", alu_b_e, 32'd7);
        check("load.alu_op", {29'd0, alu_op_e}, 32'd1);
        check("load.reg_write", {31'd0, reg_write_e}, 32'd1);
        check("load.wa", {27'd0, wa_e}, 32'd3);

        // Immediate operand B; store data still carries rt.
        drive_id(32'h3004, 32'h89AB_CDEF, 32'd5, 32'd7, 32'hFFFF_FFFC, 3'd0, 1'b1, 1'b0, 5'd0,
                 1'b1, 1'b1);
        tick();
        check("imm.alu_b", alu_b_e, 32'hFFFF_FFFC);
        check("imm.rt_fwd", rt_fwd_e, 32'd7);
        check("imm.imm_e", imm_e, 32'hFFFF_FFFC);
        check("imm.mem", {30'd0, mem_write_e, mem_to_reg_e}, 32'd3);

        // Forwarding on latched rs=1 (and rt=9, alu_src=1).
        drive_id(32'h3008, 32'h0, 32'd1, 32'd9, 32'h44, 3'd2, 1'b1, 1'b1, 5'd4, 1'b0, 1'b0);
        tick();
        rs_fwd_sel = 2'd1; fwd_m = 32'hAA; fwd_w = 32'h55;
        #1;
        check("fwd.rs_m", alu_a_e, 32'hAA);
        rs_fwd_sel = 2'd2;
        #1;
        check("fwd.rs_w", alu_a_e, 32'h55);
        rs_fwd_sel = 2'd3;
        #1;
        check("fwd.rs_sel3", alu_a_e, 32'd1);
        rt_fwd_sel = 2'd1;
        #1;
        check("fwd.rt_m", rt_fwd_e, 32'hAA);
        check("fwd.b_imm", alu_b_e, 32'h44);
        rs_fwd_sel = 2'd0; rt_fwd_sel = 2'd0;

        // Bubble beats hold.
        bubble = 1'b1; hold = 1'b1;
        drive_id(32'h3004, 32'h1111_1111, 32'd3, 32'd4, 32'd5, 3'd3, 1'b0, 1'b1, 5'd9, 1'b1, 1'b0);
        tick();
        check("bubble.valid", {31'd0, valid_e}, 32'd0);
        check("bubble.reg_write", {31'd0, reg_write_e}, 32'd0);
        check("bubble.pc", pc_e, 32'h3004);
        check("bubble.instr", instr_e, 32'd0);
        check("bubble.alu_a", alu_a_e, 32'd0);
        check("bubble.mem_write", {31'd0, mem_write_e}, 32'd0);
`ifdef IDEX_PERF_CNT_EN
        check("bubble.bubble_cnt", bubble_cnt, 32'd1);
`endif

        // Hold alone for 3 cycles after the bubble.
        bubble = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_id(32'h5000 + i, 32'hDEAD_0000 + i, 32'h20 + i, 32'h30, 32'h40, 3'd2, 1'b0, 1'b1,
                     5'd7, 1'b0, 1'b1);
            tick();
        end
        check("hold1.valid", {31'd0, valid_e}, 32'd0);
        check("hold1.pc", pc_e, 32'h3004);
        check("hold1.alu_a", alu_a_e, 32'd0);
        check("hold1.ctl", {25'd0, reg_write_e, wa_e, mem_write_e, mem_to_reg_e}, 32'd0);

        // Load real contents, then hold them while inputs change.
        hold = 1'b0;
        drive_id(32'h4000, 32'hCAFE_0001, 32'h11, 32'h22, 32'h33, 3'd3, 1'b0, 1'b1, 5'd8, 1'b0,
                 1'b1);
        tick();
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_id(32'h6000 + i, 32'hBEEF_0000 + i, 32'h99, 32'h98, 32'h97, 3'd0, 1'b1, 1'b0,
                     5'd1, 1'b1, 1'b0);
            tick();
        end
        check("hold2.valid", {31'd0, valid_e}, 32'd1);
        check("hold2.pc", pc_e, 32'h4000);
        check("hold2.instr", instr_e, 32'hCAFE_0001);
        check("hold2.alu_a", alu_a_e, 32'h11);
        check("hold2.alu_b", alu_b_e, 32'h22);
        check("hold2.alu_op", {29'd0, alu_op_e}, 32'd3);
        check("hold2.ctl", {25'd0, reg_write_e, wa_e, mem_write_e, mem_to_reg_e},
              {25'd0, 1'b1, 5'd8, 1'b0, 1'b1});
        // Forwarding stays live while holding.
        rs_fwd_sel = 2'd1; fwd_m = 32'h77;
        #1;
        check("hold2.fwd_m0", alu_a_e, 32'h77);
        fwd_m = 32'h78;
        #1;
        check("hold2.fwd_m1", alu_a_e, 32'h78);
        rt_fwd_sel = 2'd2; fwd_w = 32'h66;
        #1;
        check("hold2.fwd_b", alu_b_e, 32'h66);
        rs_fwd_sel = 2'd0; rt_fwd_sel = 2'd0;
        hold = 1'b0;

        // Flush with bubble: flush wins, everything zero.
        flush = 1'b1; bubble = 1'b1;
        drive_id(32'h7000, 32'h7777_7777, 32'h1, 32'h2, 32'h3, 3'd1, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1);
        tick();
        check_all_zero("flush");
`ifdef IDEX_PERF_CNT_EN
        check("flush.flush_cnt", flush_cnt, 32'd1);
        check("flush.bubble_cnt", bubble_cnt, 32'd1);
`endif
        flush = 1'b0; bubble = 1'b0;

        // Write to $0 is suppressed.
        drive_id(32'h8000, 32'h1, 32'h2, 32'h3, 32'h4, 3'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0);
        tick();
        check("wa0.valid", {31'd0, valid_e}, 32'd1);
        check("wa0.reg_write", {31'd0, reg_write_e}, 32'd0);
        check("wa0.pc", pc_e, 32'h8000);

        // Mid-stream reset clears everything on the next edge.
        drive_id(32'h9000, 32'h5555_AAAA, 32'h12, 32'h34, 32'h56, 3'd2, 1'b1, 1'b1, 5'd31, 1'b1,
                 1'b1);
        tick();
        check("pre_rst.valid", {31'd0, valid_e}, 32'd1);
        reset = 1'b0;
        tick();
        check_all_zero("midrst");
`ifdef IDEX_PERF_CNT_EN
        check("midrst.flush_cnt", flush_cnt, 32'd0);
        check("midrst.bubble_cnt", bubble_cnt, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/id_ex_reg.md
Name: id_ex_reg

Overview:
- ID/EX pipeline register of the 5-stage MIPS core; the stage directly upstream of the EX-stage ALU.
- Latches decoded operands and control from ID on each clock and drives the ALU A/B operands.
- Applies EX-stage forwarding and the immediate/register select for operand B.
- Implements hold, bubble insertion and flush under hazard-unit control.

Parameters:
- DW, 32, data/operand width
- RW, 5, register-address width

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-low; registers clear on the clk edge where reset==0
- hold  in  1  keep current contents (multi-cycle stall downstream)
- bubble  in  1  load a NOP (load-use stall from hazard unit)
- flush  in  1  discard the instruction in ID (branch/jump redirect)
- pc_d  in  DW  PC of the ID instruction
- instr_d  in  32  ID instruction word
- rs_data_d  in  DW  GRF rs read value
- rt_data_d  in  DW  GRF rt read value
- imm_d  in  DW  extended immediate
- alu_op_d  in  3  ALU op: 0 add, 1 sub, 2 and, 3 or
- alu_src_d  in  1  1 = B operand from immediate
- reg_write_d  in  1  GRF write enable
- wa_d  in  RW  destination register
- mem_write_d  in  1  store
- mem_to_reg_d  in  1  load
- rs_fwd_sel  in  2  0 reg, 1 MEM, 2 WB, 3 treated as 0
- rt_fwd_sel  in  2  same encoding as rs_fwd_sel
- fwd_m  in  DW  EX/MEM ALU result
- fwd_w  in  DW  WB write data
- valid_e  out  1  EX holds a real instruction
- pc_e, instr_e, imm_e  out  DW/32/DW  latched values
- alu_op_e  out  3  to ALU Op
- alu_a_e  out  DW  forwarded rs to ALU A
- alu_b_e  out  DW  alu_src_e ? imm_e : forwarded rt
- rt_fwd_e  out  DW  forwarded rt (store data to EX/MEM)
- reg_write_e, wa_e, mem_write_e, mem_to_reg_e  out  latched control

Behaviour:
- Priority at each clk edge: reset==0 > flush > bubble > hold > normal load.
- Reset: every register is 0, so valid_e=0, instr_e=0 (NOP) and all controls are 0.
- Normal load: all *_d values are latched and valid_e=1. Latency is one cycle from ID to EX.
- reg_write_e is forced to 0 when wa_d==0, so writes to $0 are never signalled.
- Flush: identical to reset, pc_e included.
- Bubble: pc_e loads pc_d; everything else is cleared, valid_e=0.
- Hold: all registers keep their values. Forwarded outputs stay combinational, so they track fwd_m/fwd_w while holding.
- bubble with hold asserted together: bubble wins.
- Forwarding is purely combinational on the latched rs/rt values and the current selects; select 3 falls back to the register value.
- alu_b_e is muxed after forwarding. rt_fwd_e always uses forwarded rt, independent of alu_src.
- No arithmetic is done in this block; widths pass through unchanged.

Optional Feature:
- Macro: IDEX_PERF_CNT_EN.
- Defined: two DW-bit saturating counters, bubble_cnt and flush_cnt, exposed as extra outputs.
  - Each counter increments on a clk edge where its event wins priority.
  - A flush with bubble asserted counts only as a flush.
  - Both counters clear on reset and stick at all-ones.
- Undefined: no counters and no extra ports.

Decomposition:
- Shared package pipe_pkg holds:
  - ALU op constants (ADD=0, SUB=1, AND=2, OR=3)
  - forward-select encodings (FWD_REG=0, FWD_M=1, FWD_W=2)
  - NOP instruction constant (0)
- Sub-module ex_fwd_mux: a 3:1 forwarding mux, instantiated twice (rs and rt).

Test Plan:
- Reset, then load pc_d=0x3000, rs=5, rt=7, alu_op=1, alu_src=0 → next cycle alu_a_e=5, alu_b_e=7, valid_e=1, alu_op_e=1.
- alu_src_d=1, imm_d=0xFFFF_FFFC → alu_b_e=0xFFFF_FFFC, while rt_fwd_e still equals rt.
- Latched rs=1, rs_fwd_sel=1, fwd_m=0xAA → alu_a_e=0xAA. Switch to sel=2 with fwd_w=0x55 → 0x55. Switch to sel=3 → 1.
- bubble and hold both asserted with pc_d=0x3004 → valid_e=0, reg_write_e=0, pc_e=0x3004. Then hold alone for 3 cycles → all outputs unchanged.
- flush and bubble asserted together → all outputs 0. With IDEX_PERF_CNT_EN: flush_cnt+1, bubble_cnt unchanged.
- reg_write_d=1, wa_d=0 → reg_write_e=0. Drive reset=0 mid-stream → next edge all outputs 0.
